// File: rtl/ucie_sb_tx_arbiter.sv
// Sideband transmit arbiter: round-robin grant of one single-beat message per slot,
// followed by GAP_CYCLES idle cycles. Define UCIE_SB_ARB_PRIO_EN for strict priority on requester 0.
module ucie_sb_tx_arbiter #(
  parameter int NC         = 32,
  parameter int MSG_W      = 4,
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sb_enable,
  input  logic                   i_sb_flush,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*MSG_W-1:0] i_req_msg,
  input  logic [N_REQ*NC-1:0]    i_req_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [MSG_W-1:0]       o_sb_msg_out,
  output logic [NC-1:0]          o_data_sent_sb,
  output logic                   o_sb_data_valid,
  output logic                   o_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [NC-1:0]      data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   cand_s;
  logic [PTR_W-1:0]   win_s;
  logic [PTR_W-1:0]   ptr_inc_s;
  logic               prio_win_s;
  logic               hit_s;
  logic               found_s;

  // Explicit wrap so non-power-of-two requester counts stay in range.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Winner selection: upward search from rr_ptr_q, optionally pre-empted by requester 0.
  always_comb begin
    cand_s     = i_req;
    prio_win_s = 1'b0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    win_s      = '0;
`ifdef UCIE_SB_ARB_PRIO_EN
    prio_win_s = i_req[0];
    cand_s[0]  = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      hit_s   = !found_s && cand_s[wrap_idx(rr_ptr_q, i)];
      win_s   = hit_s ? wrap_idx(rr_ptr_q, i) : win_s;
      found_s = found_s | hit_s;
    end
    if (prio_win_s) begin
      win_s = '0;
    end else begin
      win_s = win_s;
    end
    ptr_inc_s = (win_s == PTR_W'(N_REQ - 1)) ? '0 : win_s + PTR_W'(1);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = '0;
    msg_d    = '0;
    data_d   = '0;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_sb_flush) begin
          state_d = ST_IDLE;
        end else if (i_sb_enable && (|i_req)) begin
          state_d        = ST_SEND;
          gnt_d[win_s]   = 1'b1;
          valid_d        = 1'b1;
          msg_d          = i_req_msg[int'(win_s)*MSG_W +: MSG_W];
          data_d         = i_req_data[int'(win_s)*NC +: NC];
          rr_ptr_d       = prio_win_s ? rr_ptr_q : ptr_inc_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_sb_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (i_sb_flush || (cnt_q == '0)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      msg_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      msg_q    <= msg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_gnt           = gnt_q;
  assign o_sb_msg_out    = msg_q;
  assign o_data_sent_sb  = data_q;
  assign o_sb_data_valid = valid_q;
  assign o_busy          = busy_q;

endmodule

// File: doc/ucie_sb_tx_arbiter.md
# ucie_sb_tx_arbiter

Sideband transmit arbiter for one die adapter. Shares the single die-to-die sideband channel (`o_sb_msg_out`, `o_sb_data_valid`, `o_data_sent_sb`) among N_REQ internal requesters: link-state FSM messages, CSR/parameter exchange and error reporting. Serialises one message per slot with a programmable inter-message gap, so the remote die's sideband decoder always sees isolated single-cycle valid beats.

## Interface
- `NC`, 32: sideband data width in bits.
- `MSG_W`, 4: sideband message code width.
- `N_REQ`, 3: number of requesters (2..8).
- `GAP_CYCLES`, 1: idle cycles forced after every sent message (0..15).

Ports:
- `i_clk` input 1: single clock.
- `i_rst_n` input 1: reset; synchronous, active-low.
- `i_sb_enable` input 1: arbitration allowed (link sideband up).
- `i_sb_flush` input 1: abort current slot and return to IDLE.
- `i_req` input N_REQ: per-requester request level.
- `i_req_msg` input N_REQ*MSG_W: per-requester message code; slice k belongs to requester k.
- `i_req_data` input N_REQ*NC: per-requester payload; slice k belongs to requester k.
- `o_gnt` output N_REQ: one-hot grant pulse.
- `o_sb_msg_out` output MSG_W: message code to remote die.
- `o_data_sent_sb` output NC: payload to remote die.
- `o_sb_data_valid` output 1: message/payload valid.
- `o_busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states are IDLE, SEND and GAP.
- **IDLE:** if `i_sb_enable` is high, `i_sb_flush` is low and `i_req` is nonzero, select the winner `w` and go to SEND. Otherwise stay in IDLE.
- **Winner selection:** round-robin. Search starts at pointer `rr_ptr` and goes upward, wrapping from N_REQ-1 to 0.
- **Pointer update:** on a grant, `rr_ptr` becomes (w+1) mod N_REQ. Wrap is explicit; no power-of-two assumption.
- **Entry to SEND (registered):**
  - `o_gnt[w]` = 1.
  - `o_sb_data_valid` = 1.
  - `o_sb_msg_out` and `o_data_sent_sb` are loaded from slice `w`.
- **SEND:** lasts exactly 1 cycle. Next state is GAP if GAP_CYCLES > 0, else IDLE. `i_req` is ignored in SEND.
- **GAP:** a down-counter is loaded with GAP_CYCLES-1 on entry. Exit to IDLE when the counter reaches 0. `i_req` is ignored in GAP.
- **Output defaults:**
  - `o_gnt`, `o_sb_data_valid`: 0 in every cycle except SEND.
  - `o_sb_msg_out`, `o_data_sent_sb`: all-zero outside SEND (NOP code 0).
- **Flush:** `i_sb_flush` high in any state, synchronous, means the next state is IDLE.
  - All outputs return to their reset values.
  - `rr_ptr` is kept.
  - A grant already issued in SEND still counts as consumed.
  - Flush takes priority over a new grant in the same cycle.
- **Enable low:** `i_sb_enable` low only blocks new grants from IDLE. A SEND or GAP already in progress completes.
- **Requester contract:**
  - Hold `i_req`, msg and data stable until `o_gnt` is seen.
  - Deassert `i_req` at the edge that ends the grant cycle, or keep it high for a further message with new msg/data.
  - The arbiter takes no payload after grant.
- **Reset:** when `i_rst_n` is low at a rising edge:
  - state = IDLE, counter = 0, `rr_ptr` = 0;
  - all outputs = 0.
  - Reset in mid-SEND drops the message; no partial beat.

## Timing
- Request to valid: `i_req` seen high in IDLE at edge t gives `o_sb_data_valid` = `o_gnt[w]` = 1 during cycle t+1 (1-cycle latency).
- Throughput: one message per 2+GAP_CYCLES cycles. With GAP_CYCLES=0, back-to-back valids are separated by exactly 1 IDLE cycle.
- Grant and valid are always the same cycle, and they are one-hot.
- `o_busy` is registered with the state.

## Configuration
- Macro: `UCIE_SB_ARB_PRIO_EN`.
- **Defined:** requester 0 (error reporting) has strict priority.
  - Whenever `i_req[0]` is high in IDLE, it wins.
  - Requesters 1..N_REQ-1 round-robin among themselves.
  - Grants to requester 0 do not move `rr_ptr`.
- **Undefined:** pure round-robin over all N_REQ requesters.

## Test plan
- **Single request:** N_REQ=3, GAP=1, reset then enable, `i_req`=3'b010, msg 4'h5, data 32'hA5A5_0001 → next cycle `o_gnt`=3'b010, valid=1, msg=5, data=A5A5_0001. Then 1 GAP cycle, then IDLE; `o_busy` high for 2 cycles.
- **Round-robin fairness:** all three requests held continuously, GAP=0, macro undefined → grant order 0,1,2,0,1,2, valids every 2nd cycle.
- **Strict priority:** macro defined, `i_req`=3'b111 continuously → requester 0 is always granted. Then drop `i_req[0]` → order alternates 1,2,1. The pointer is not disturbed by the requester-0 grants.
- **Flush mid-gap:** GAP=4, flush asserted in the 2nd GAP cycle → IDLE at the next edge, outputs 0. A pending request is granted on the following edge, with the pointer continuing from the last winner.
- **Enable and reset:** with `i_sb_enable`=0 and requests pending → no grant for 10 cycles. Assert `i_rst_n`=0 during SEND → next edge all outputs 0, `rr_ptr`=0.
